// File: rtl/sdram_rw_arbiter_if.sv
// Burst port between the frame-buffer arbiter (master) and the SDRAM controller (slave).
interface sdram_rw_arbiter_if;
  logic        intf_wr_req;
  logic        intf_rd_req;
  logic [24:0] intf_rw_addr;
  logic        intf_ack;
  logic [15:0] intf_rd_data;
  logic        intf_rd_data_vld;

  modport master (
    output intf_wr_req, intf_rd_req, intf_rw_addr,
    input  intf_ack, intf_rd_data, intf_rd_data_vld
  );

  modport slave (
    input  intf_wr_req, intf_rd_req, intf_rw_addr,
    output intf_ack, intf_rd_data, intf_rd_data_vld
  );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// Round-robin burst arbiter sharing one SDRAM burst port between the camera-side write FIFO
// and the VGA-side read FIFO, with per-side linear frame addressing.
module sdram_rw_arbiter #(
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [24:0] WR_BASE     = 25'd0,
  parameter logic [24:0] RD_BASE     = 25'd0,
  parameter int unsigned LVL_W       = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [LVL_W-1:0]    wr_level,
  output logic                wr_pop,
  input  logic                wr_frame_start,
  input  logic [LVL_W-1:0]    rd_space,
  output logic                rd_push,
  output logic [15:0]         rd_push_data,
  input  logic                rd_frame_start,
  sdram_rw_arbiter_if.master  intf,
  output logic                busy
);

  localparam int unsigned     CntW      = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] LastBeat  = CntW'(BURST_LEN - 1);
  localparam logic [24:0]     BurstStep = 25'(BURST_LEN);
  localparam logic [24:0]     FrameEnd  = 25'(FRAME_WORDS);
  localparam logic [LVL_W-1:0] LvlBurst = LVL_W'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRdWait} state_e;

  state_e          state_q;
  logic [24:0]     wr_off_q, rd_off_q;
  logic            last_rd_q;
  logic            wr_pend_q, rd_pend_q;
  logic [CntW-1:0] ack_cnt_q, vld_cnt_q;
  logic            wr_req_q, rd_req_q;
  logic [24:0]     addr_q;

  logic wr_rdy, rd_rdy, grant_wr, grant_rd;
  logic wr_done, rd_done, wr_side, rd_side;

  function automatic logic [24:0] adv(input logic [24:0] off);
    return (off + BurstStep == FrameEnd) ? '0 : off + BurstStep;
  endfunction

  assign wr_rdy   = en & (wr_level >= LvlBurst);
  assign rd_rdy   = en & (rd_space >= LvlBurst);
  // Write wins a tie unless it had the previous grant.
  assign grant_wr = (state_q == StIdle) & wr_rdy & (~rd_rdy | last_rd_q);
  assign grant_rd = (state_q == StIdle) & rd_rdy & ~grant_wr;

  assign wr_done = (state_q == StWr) & intf.intf_ack & (ack_cnt_q == LastBeat);
  assign rd_done = (state_q == StRdWait) & intf.intf_rd_data_vld & (vld_cnt_q == LastBeat);

  // A side being granted this cycle already counts as mid-burst for frame-start purposes.
  assign wr_side = (state_q == StWr) | grant_wr;
  assign rd_side = (state_q == StRd) | (state_q == StRdWait) | grant_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      last_rd_q <= 1'b1;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      ack_cnt_q <= '0;
      vld_cnt_q <= '0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      addr_q    <= WR_BASE;
    end else begin
      if (wr_done) begin
        wr_off_q  <= (wr_pend_q | wr_frame_start) ? '0 : adv(wr_off_q);
        wr_pend_q <= 1'b0;
      end else if (wr_frame_start) begin
        if (wr_side) wr_pend_q <= 1'b1;
        else         wr_off_q  <= '0;
      end

      if (rd_done) begin
        rd_off_q  <= (rd_pend_q | rd_frame_start) ? '0 : adv(rd_off_q);
        rd_pend_q <= 1'b0;
      end else if (rd_frame_start) begin
        if (rd_side) rd_pend_q <= 1'b1;
        else         rd_off_q  <= '0;
      end

      unique case (state_q)
        StIdle: begin
          ack_cnt_q <= '0;
          vld_cnt_q <= '0;
          if (grant_wr) begin
            state_q   <= StWr;
            wr_req_q  <= 1'b1;
            addr_q    <= WR_BASE + wr_off_q;
            last_rd_q <= 1'b0;
          end else if (grant_rd) begin
            state_q   <= StRd;
            rd_req_q  <= 1'b1;
            addr_q    <= RD_BASE + rd_off_q;
            last_rd_q <= 1'b1;
          end
        end
        StWr: begin
          // Drop req after the first ack so the controller cannot start a second burst.
          if (intf.intf_ack) begin
            wr_req_q  <= 1'b0;
            ack_cnt_q <= ack_cnt_q + 1'b1;
            if (ack_cnt_q == LastBeat) state_q <= StIdle;
          end
        end
        StRd: begin
          if (intf.intf_ack) begin
            rd_req_q  <= 1'b0;
            ack_cnt_q <= ack_cnt_q + 1'b1;
            if (ack_cnt_q == LastBeat) state_q <= StRdWait;
          end
          if (intf.intf_rd_data_vld) vld_cnt_q <= vld_cnt_q + 1'b1;
        end
        StRdWait: begin
          if (intf.intf_rd_data_vld) begin
            vld_cnt_q <= vld_cnt_q + 1'b1;
            if (vld_cnt_q == LastBeat) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_pop            = (state_q == StWr) & intf.intf_ack;
  assign rd_push           = intf.intf_rd_data_vld & ((state_q == StRd) | (state_q == StRdWait));
  assign rd_push_data      = intf.intf_rd_data;
  assign intf.intf_wr_req  = wr_req_q;
  assign intf.intf_rd_req  = rd_req_q;
  assign intf.intf_rw_addr = addr_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Randomized bench for sdram_rw_arbiter: SDRAM controller stand-in plus a burst-level
// reference model compared against the DUT every cycle, with literal spot checks.
module tb_sdram_rw_arbiter;
  localparam int unsigned BL = 8;
  localparam int unsigned FW = 64;
  localparam logic [24:0] WB = 25'h100000;
  localparam logic [24:0] RB = 25'h0a0040;
  localparam int unsigned LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [LW-1:0] wr_level = '0;
  logic [LW-1:0] rd_space = '0;
  logic          wr_frame_start = 1'b0;
  logic          rd_frame_start = 1'b0;
  logic          wr_pop, rd_push, busy;
  logic [15:0]   rd_push_data;

  sdram_rw_arbiter_if bus ();

  sdram_rw_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .WR_BASE(WB), .RD_BASE(RB), .LVL_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wr_level(wr_level), .wr_pop(wr_pop), .wr_frame_start(wr_frame_start),
    .rd_space(rd_space), .rd_push(rd_push), .rd_push_data(rd_push_data),
    .rd_frame_start(rd_frame_start), .intf(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which side owns the port, words transferred, per-side offsets.
  int          m_side;  // 0 none, 1 write, 2 read
  int          m_acks, m_vlds;
  bit          m_req, m_last_rd, m_wr_pend, m_rd_pend;
  int          m_wr_off, m_rd_off;
  logic [24:0] m_addr;

  function automatic int nxt(input int off);
    return (off + BL == FW) ? 0 : off + BL;
  endfunction

  task automatic model_reset();
    m_side = 0; m_acks = 0; m_vlds = 0; m_req = 0; m_last_rd = 1;
    m_wr_pend = 0; m_rd_pend = 0; m_wr_off = 0; m_rd_off = 0; m_addr = WB;
  endtask

  task automatic model_step();
    bit wr_rdy, rd_rdy, g_wr, g_rd;
    int side0;
    if (!rst_n) begin
      model_reset();
    end else begin
      side0  = m_side;
      wr_rdy = en && (wr_level >= BL);
      rd_rdy = en && (rd_space >= BL);
      g_wr = 0;
      g_rd = 0;
      if (side0 == 0) begin
        g_wr = wr_rdy && (!rd_rdy || m_last_rd);
        g_rd = rd_rdy && !g_wr;
      end
      if (wr_frame_start) begin
        if (side0 == 1 || g_wr) m_wr_pend = 1; else m_wr_off = 0;
      end
      if (rd_frame_start) begin
        if (side0 == 2 || g_rd) m_rd_pend = 1; else m_rd_off = 0;
      end
      if (side0 == 1 && bus.intf_ack) begin
        m_req = 0;
        m_acks++;
        if (m_acks == BL) begin
          m_wr_off  = m_wr_pend ? 0 : nxt(m_wr_off);
          m_wr_pend = 0;
          m_side    = 0;
        end
      end
      if (side0 == 2) begin
        if (bus.intf_ack) begin m_req = 0; m_acks++; end
        if (bus.intf_rd_data_vld) m_vlds++;
        if (m_vlds == BL) begin
          m_rd_off  = m_rd_pend ? 0 : nxt(m_rd_off);
          m_rd_pend = 0;
          m_side    = 0;
        end
      end
      if (g_wr) begin
        m_side = 1; m_req = 1; m_addr = WB + 25'(m_wr_off);
        m_acks = 0; m_vlds = 0; m_last_rd = 0;
      end
      if (g_rd) begin
        m_side = 2; m_req = 1; m_addr = RB + 25'(m_rd_off);
        m_acks = 0; m_vlds = 0; m_last_rd = 1;
      end
    end
  endtask

  // SDRAM controller stand-in: random ack latency, read data 3 cycles behind each ack.
  int          s_mode, s_lat, s_acks_left, s_beat;
  int          s_idx = 0;
  logic [2:0]  s_sr;
  logic [15:0] s_exp;

  task automatic slave_reset();
    s_mode = 0; s_lat = 0; s_acks_left = 0; s_beat = 0; s_sr = '0; s_exp = '0;
    bus.intf_ack = 1'b0;
    bus.intf_rd_data_vld = 1'b0;
    bus.intf_rd_data = '0;
  endtask

  task automatic slave_step();
    logic ack_new, vld_new;
    vld_new = s_sr[2];
    bus.intf_rd_data_vld = vld_new;
    if (vld_new) begin
      s_exp = 16'h1000 + 16'(s_idx * 16 + s_beat);
      bus.intf_rd_data = s_exp;
      s_beat++;
      if (s_beat == BL) begin s_beat = 0; s_idx++; end
    end else begin
      bus.intf_rd_data = 16'($urandom);
    end
    ack_new = 1'b0;
    if (s_mode == 0 && (bus.intf_wr_req || bus.intf_rd_req)) begin
      s_mode      = bus.intf_wr_req ? 1 : 2;
      s_lat       = $urandom_range(0, 3);
      s_acks_left = BL;
    end
    if (s_mode != 0 && s_acks_left > 0) begin
      if (s_lat > 0) s_lat--;
      else begin ack_new = 1'b1; s_acks_left--; end
    end
    bus.intf_ack = ack_new;
    s_sr = {s_sr[1:0], ack_new && (s_mode == 2)};
    if (s_mode != 0 && s_acks_left == 0 && s_sr == 3'b000) s_mode = 0;
  endtask

  // Monitors feeding the literal checks.
  logic [24:0] wr_addrs[$];
  logic [24:0] rd_addrs[$];
  int          pops_at_grant[$];
  logic [15:0] rd_log[$];
  int          pop_total = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;

  task automatic compare();
    chk("wr_req", bus.intf_wr_req, m_req && m_side == 1);
    chk("rd_req", bus.intf_rd_req, m_req && m_side == 2);
    chk("addr", bus.intf_rw_addr, m_addr);
    chk("busy", busy, m_side != 0);
    chk("wr_pop", wr_pop, m_side == 1 && bus.intf_ack);
    chk("rd_push", rd_push, m_side == 2 && bus.intf_rd_data_vld);
    if (m_side == 2 && bus.intf_rd_data_vld) chk("rd_push_data", rd_push_data, s_exp);
  endtask

  // Entered and left at a negedge: drive, check, then advance the model on the posedge.
  task automatic cycle();
    if (!rst_n) begin model_reset(); slave_reset(); end
    else slave_step();
    #1;
    compare();
    if (rst_n) begin
      if (bus.intf_wr_req && !prev_wr) begin
        wr_addrs.push_back(bus.intf_rw_addr);
        pops_at_grant.push_back(pop_total);
      end
      if (bus.intf_rd_req && !prev_rd) rd_addrs.push_back(bus.intf_rw_addr);
      if (wr_pop) pop_total++;
      if (rd_push) rd_log.push_back(rd_push_data);
    end
    prev_wr = bus.intf_wr_req;
    prev_rd = bus.intf_rd_req;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int n, n0;
    model_reset();
    slave_reset();
    @(negedge clk);
    repeat (3) cycle();
    chk("reset_addr", bus.intf_rw_addr, 25'h100000);

    // Enable low: nothing may be granted.
    rst_n = 1'b1; en = 1'b0; wr_level = 100;
    repeat (50) cycle();
    chk("no_grant_en0", wr_addrs.size() + rd_addrs.size(), 0);

    // Write-only traffic.
    en = 1'b1; wr_level = 8; rd_space = 0;
    for (int i = 0; i < 200 && wr_addrs.size() < 2; i++) cycle();
    chk("wr_grants", wr_addrs.size(), 2);
    if (wr_addrs.size() >= 2) begin
      chk("wr_addr0", wr_addrs[0], 25'h100000);
      chk("wr_addr1", wr_addrs[1], 25'h100008);
      chk("wr_pop_count", pops_at_grant[1] - pops_at_grant[0], 8);
    end

    // Both sides ready: alternation, read data, write-offset wrap.
    wr_level = 64; rd_space = 64;
    repeat (400) cycle();
    chk("rd_seen", rd_log.size() >= 8, 1);
    if (rd_log.size() >= 8)
      for (int i = 0; i < 8; i++) chk("rd_data_first", rd_log[i], 16'h1000 + 16'(i));
    chk("rd_grants_seen", rd_addrs.size() >= 2, 1);
    if (rd_addrs.size() >= 2) begin
      chk("rd_addr0", rd_addrs[0], 25'h0a0040);
      chk("rd_addr1", rd_addrs[1], 25'h0a0048);
    end
    chk("wr_wrap_seen", wr_addrs.size() >= 9, 1);
    if (wr_addrs.size() >= 9) chk("wr_wrap_addr", wr_addrs[8], 25'h100000);

    // Write frame start in the middle of a burst.
    rd_space = 0;
    n0 = pop_total;
    for (int i = 0; i < 100 && pop_total == n0; i++) cycle();
    n = wr_addrs.size();
    wr_frame_start = 1'b1;
    cycle();
    wr_frame_start = 1'b0;
    for (int i = 0; i < 100 && wr_addrs.size() <= n; i++) cycle();
    chk("fs_grant_seen", wr_addrs.size() > n, 1);
    if (wr_addrs.size() > n) chk("fs_addr", wr_addrs[n], 25'h100000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) wr_level = LW'($urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) rd_space = LW'($urandom_range(0, 16));
      wr_frame_start = ($urandom_range(0, 39) == 0);
      rd_frame_start = ($urandom_range(0, 39) == 0);
      cycle();
    end
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;

    // Reset in the middle of a read burst.
    en = 1'b1; wr_level = 0; rd_space = 64;
    n0 = rd_log.size();
    for (int i = 0; i < 200 && rd_log.size() == n0; i++) cycle();
    chk("rd_push_seen", rd_log.size() > n0, 1);
    rst_n = 1'b0;
    cycle();
    chk("rst_rd_req", bus.intf_rd_req, 0);
    chk("rst_rd_push", rd_push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus.intf_rw_addr, 25'h100000);
    cycle();
    rst_n = 1'b1;
    n = rd_addrs.size();
    for (int i = 0; i < 100 && rd_addrs.size() <= n; i++) cycle();
    chk("rst_rd_grant_seen", rd_addrs.size() > n, 1);
    if (rd_addrs.size() > n) chk("rst_rd_addr", rd_addrs[n], 25'h0a0040);
    repeat (40) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
